// File: rtl/data_mem_sized_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_sized_if : request/response bundle between MEM stage and data memory
// Revision 1.0
// ---------------------------------------------------------------------------
interface data_mem_sized_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_sized.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_sized : handshaked byte/half/word data memory with optional wait states
// Option macro: DMEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses)
// Revision 1.0
// ---------------------------------------------------------------------------
module data_mem_sized #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 17,
  parameter int WAIT_STATES = 0
) (
  input wire              clock,
  input wire              reset,
  data_mem_sized_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              do_access;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_signed;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [DEPTH_LOG2+1:0] eff_addr;
  logic              trap;
  logic [3:0]        be;
  logic [31:0]       wshift;
  logic [31:0]       word;
  logic [31:0]       shifted;
  logic [31:0]       ext;
  logic              unused_addr_hi;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign accept = bus.req_valid && (state == S_IDLE);

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request; otherwise the latched copy is the only valid source.
  assign acc_we     = (state == S_IDLE) ? bus.req_we     : lat_we;
  assign acc_size   = (state == S_IDLE) ? bus.req_size   : lat_size;
  assign acc_signed = (state == S_IDLE) ? bus.req_signed : lat_signed;
  assign acc_addr   = (state == S_IDLE) ? bus.req_addr   : lat_addr;
  assign acc_wdata  = (state == S_IDLE) ? bus.req_wdata  : lat_wdata;
  assign unused_addr_hi = ^acc_addr[ADDR_W-1:DEPTH_LOG2+2];

  assign do_access = reset &&
                     (((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1)));

  always_comb begin
    eff_addr = acc_addr[DEPTH_LOG2+1:0];
    trap     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (acc_size == 2'b01)
      trap = acc_addr[0];
    else if (acc_size[1])
      trap = (acc_addr[1:0] != 2'b00);
`else
    if (acc_size == 2'b01)
      eff_addr[0] = 1'b0;
    else if (acc_size[1])
      eff_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    be = 4'b1111;
    case (acc_size)
      2'b00:   be = 4'b0001 << eff_addr[1:0];
      2'b01:   be = eff_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    wshift  = acc_wdata << {eff_addr[1:0], 3'b000};
    word    = mem[eff_addr[DEPTH_LOG2+1:2]];
    shifted = word >> {eff_addr[1:0], 3'b000};
    case (acc_size)
      2'b00:   ext = acc_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'd0, shifted[7:0]};
      2'b01:   ext = acc_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'd0, shifted[15:0]};
      default: ext = word;
    endcase
  end

  // RAM has no reset; the reset gating lives in do_access.
  always_ff @(posedge clock) begin
    if (do_access && acc_we && !trap) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[eff_addr[DEPTH_LOG2+1:2]][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) next_state = S_RESP;
      S_RESP:  if (bus.resp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
    end else begin
      if (accept) begin
        lat_we     <= bus.req_we;
        lat_size   <= bus.req_size;
        lat_signed <= bus.req_signed;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
        cnt        <= WS;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rdata_q <= (acc_we || trap) ? 32'd0 : ext;
        err_q   <= trap;
      end
    end
  end
endmodule
`default_nettype wire
